edabk_transmitter_controller: RTL

//  Control FSM directly upstream of the transmitter datapath. Accepts one byte per

---
 rtl/edabk_transmitter_controller.sv | 126 ++++++++++++
 1 files changed

// File: rtl/edabk_transmitter_controller.sv
// edabk_transmitter_controller
// UART transmit sequencer. Accepts one byte per valid/ready handshake and drives
// the datapath load/shift/clear strobes from the datapath's per-bit done pulse,
// giving start bit, DATA_WIDTH data bits LSB-first, then the stop bit(s).
// Build option: define CFG_TX_TWO_STOP_EN for two stop bits (default is one).

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_transmitter_controller #(
  parameter int DATA_WIDTH    = `CFG_DATA_WIDTH,
  parameter int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic bclk,
  input  logic reset,
  input  logic tx_valid,
  output logic tx_ready,
  input  logic done,
  output logic load,
  output logic shift,
  output logic clear,
  output logic tx_busy,
  output logic tx_done
);

`ifdef CFG_TX_TWO_STOP_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_STOP2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

  localparam logic [BIT_CNT_WIDTH-1:0] LAST_CNT = BIT_CNT_WIDTH'(DATA_WIDTH);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
  logic [BIT_CNT_WIDTH-1:0] w_bit_cnt_next;

  // State and bit counter registers; reset abandons any frame in progress
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  // Next-state logic and combinational strobes; strobes stay unregistered so a
  // bit period is exactly one done interval long
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    tx_ready       = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    clear          = 1'b0;
    tx_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // done is meaningless here; only a handshake starts a frame
        tx_ready = 1'b1;
        if (tx_valid) begin
          load           = 1'b1;
          w_bit_cnt_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        // The done with bit_cnt==DATA_WIDTH ends the last data bit; that shift
        // leaves the datapath all ones, which is the stop bit on the line
        if (done) begin
          shift = 1'b1;
          if (r_bit_cnt == LAST_CNT) begin
            w_bit_cnt_next = '0;
            w_state_next   = S_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_CNT_WIDTH'(1);
          end
        end
      end
      S_STOP: begin
        if (done) begin
`ifdef CFG_TX_TWO_STOP_EN
          // Line is already all ones; just hold it for another bit period
          w_state_next = S_STOP2;
`else
          clear        = 1'b1;
          tx_done      = 1'b1;
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef CFG_TX_TWO_STOP_EN
      S_STOP2: begin
        if (done) begin
          clear        = 1'b1;
          tx_done      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next   = S_IDLE;
        w_bit_cnt_next = '0;
      end
    endcase
    // Every output is forced low while reset is held, independent of the clock
    if (reset) begin
      tx_ready = 1'b0;
      load     = 1'b0;
      shift    = 1'b0;
      clear    = 1'b0;
      tx_done  = 1'b0;
    end
  end

  assign tx_busy = (r_state != S_IDLE) && !reset;

  // load, shift and clear drive the same datapath register and must never overlap
  a_strobe_onehot0: assert property (@(posedge bclk) disable iff (reset)
    $onehot0({load, shift, clear}));

endmodule
